vga_write_scheduler: RTL
========================

// Module: vga_write_scheduler
// PURPOSE
//  Owns the single pixel-write port of the VGA adapter and shares it between two users.
//  - Screen-clear sweep: paints every pixel with the background colour.
//  - Cursor plot requests: one pixel per request, from the drawing controller's PLOT step.
//  Sits between the drawing controller / position datapath and the VGA adapter.
//  A clear always wins the port; a plot never interleaves with a sweep.
// PARAMETERS
//  WIDTH          160     screen width in pixels
//  HEIGHT         120     screen height in pixels
//  XW             8       x coordinate width, 2**XW >= WIDTH
//  YW             7       y coordinate width, 2**YW >= HEIGHT
//  CW             3       colour width
//  BG_COLOUR      3'b000  colour written by a clear sweep
//  CLEAR_ON_RESET 1       1: run a clear sweep automatically after reset
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  clear_req   in   1   one-cycle pulse: request a full-screen clear
//  plot_valid  in   1   plot request valid
//  plot_ready  out  1   scheduler accepts plot request this cycle
//  plot_x      in   XW  plot x coordinate
//  plot_y      in   YW  plot y coordinate
//  plot_colour in   CW  plot colour
//  vga_x       out  XW  adapter x coordinate
//  vga_y       out  YW  adapter y coordinate
//  vga_colour  out  CW  adapter colour
//  vga_plot    out  1   adapter write strobe
//  clear_busy  out  1   high while a clear sweep is in progress
//  clear_done  out  1   one-cycle pulse after the last sweep pixel
//  plot_oob    out  1   one-cycle pulse: accepted plot was off-screen and dropped
// BEHAVIOUR
//  Reset values:
//   - vga_x/vga_y/vga_colour = 0; vga_plot, clear_done, plot_oob = 0; clear_pending = 0.
//   - State = CLEAR if CLEAR_ON_RESET, else IDLE.
//   - Reset mid-sweep or mid-plot abandons the operation and zeroes the counters.
//  Outputs: all registered except plot_ready.
//   - plot_ready = (state==IDLE) && !clear_req && !clear_pending.
//  Handshake: a transfer occurs when plot_valid && plot_ready are both high.
//   - Coordinates and colour are sampled on that edge.
//   - plot_x/plot_y/plot_colour are ignored while ready is low.
//  States:
//   - IDLE
//     - clear_req or clear_pending -> CLEAR, pending cleared.
//     - Else a transfer -> PLOT.
//   - PLOT (1 cycle)
//     - In range: vga_* = sampled values, vga_plot = 1.
//     - Off-screen (x >= WIDTH or y >= HEIGHT): vga_plot = 0, plot_oob = 1.
//     - Next state: IDLE. A clear_req seen in PLOT sets clear_pending.
//   - CLEAR
//     - Raster sweep: x 0..WIDTH-1 fastest, then y 0..HEIGHT-1.
//     - Each cycle: vga_plot = 1, vga_colour = BG_COLOUR.
//     - Duration: exactly WIDTH*HEIGHT cycles.
//     - On the cycle after pixel (WIDTH-1, HEIGHT-1): clear_done = 1, clear_busy = 0, state -> IDLE.
//     - clear_req during CLEAR restarts the sweep at (0,0) on the next cycle; no clear_done for the aborted sweep.
//  clear_busy = (state==CLEAR), registered.
//  Plot latency: 1 cycle from transfer to vga_plot. Throughput: 1 plot per 2 cycles.
//  Simultaneous clear_req and plot_valid in IDLE: clear wins; ready is low, so no transfer.
//  Counter wrap: x resets to 0 at WIDTH-1; widths never overflow because 2**XW >= WIDTH.
// STRUCTURE
//  Shared package:
//   - Screen constants (WIDTH, HEIGHT, XW, YW, CW, BG_COLOUR).
//   - State encodings IDLE/PLOT/CLEAR.
//  Sub-module raster_counter:
//   - Inputs: en, restart. Outputs: x, y, last.
//   - Reused later for screen-readback sweeps.
//  Top level: FSM, clear_pending flag, output registers.
// TESTING
//  Directed tests use WIDTH=4, HEIGHT=3 except the default-size reset test.
//  1. Reset with CLEAR_ON_RESET=1:
//     - 12 consecutive vga_plot cycles, raster order (0,0)..(3,2), colour BG.
//     - clear_done on cycle 13; plot_ready high afterwards.
//  2. Plot (2,1,colour 5) in IDLE:
//     - Next cycle: vga_plot=1, vga_x=2, vga_y=1, vga_colour=5.
//     - plot_ready low that cycle, high the cycle after.
//  3. Back-to-back plot_valid held for 4 cycles:
//     - Exactly 2 transfers, at cycles 0 and 2.
//  4. Plot (4,0):
//     - vga_plot stays 0; plot_oob pulses once; next plot (3,2) is drawn normally.
//  5. clear_req on the same cycle as plot_valid:
//     - No transfer; a sweep starts.
//     - clear_req at pixel 6 restarts at (0,0).
//     - clear_done only after a full 12-pixel run.
//  6. clear_req during PLOT:
//     - The plot completes, then the sweep starts the next cycle.
//     - Reset asserted mid-sweep -> sweep restarts at (0,0) after reset (CLEAR_ON_RESET=1).

Source files
------------

// File: rtl/vga_write_scheduler_pkg.sv
// Shared screen constants and scheduler state encoding for the VGA write path.
package vga_write_scheduler_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;
  localparam int SCREEN_XW     = 8;
  localparam int SCREEN_YW     = 7;
  localparam int SCREEN_CW     = 3;
  localparam logic [SCREEN_CW-1:0] SCREEN_BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLOT  = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/vga_write_scheduler_raster.sv
// Raster position counter: x runs fastest over 0..WIDTH-1, then y over 0..HEIGHT-1.
module raster_counter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int XW     = 8,
  parameter int YW     = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          restart,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] base_x, next_x;
  logic [YW-1:0] base_y, next_y;

  // restart rewinds to the origin first, so restart together with en lands on the second pixel
  always_comb begin
    base_x = restart ? '0 : x;
    base_y = restart ? '0 : y;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    next_x = base_x;
    next_y = base_y;
    if (en) begin
      if (base_x == XW'(WIDTH - 1)) begin
        next_x = '0;
        next_y = (base_y == YW'(HEIGHT - 1)) ? '0 : base_y + YW'(1);
      end else begin
        next_x = base_x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= next_x;
      y <= next_y;
    end
  end

  assign last = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));

endmodule

// File: rtl/vga_write_scheduler.sv
// Arbitrates the single VGA pixel-write port between full-screen clear sweeps and cursor plots.
module vga_write_scheduler
  import vga_write_scheduler_pkg::*;
#(
  parameter int            WIDTH          = SCREEN_WIDTH,
  parameter int            HEIGHT         = SCREEN_HEIGHT,
  parameter int            XW             = SCREEN_XW,
  parameter int            YW             = SCREEN_YW,
  parameter int            CW             = SCREEN_CW,
  parameter logic [CW-1:0] BG_COLOUR      = CW'(SCREEN_BG_COLOUR),
  parameter bit            CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  input  logic          plot_valid,
  output logic          plot_ready,
  input  logic [XW-1:0] plot_x,
  input  logic [YW-1:0] plot_y,
  input  logic [CW-1:0] plot_colour,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          plot_oob
);

  localparam bit SINGLE_PIXEL = (WIDTH * HEIGHT == 1);

  state_t        state;
  logic          clear_pending;
  logic          sweep_end;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          cnt_last;
  logic          cnt_en;
  logic          cnt_restart;
  logic          transfer;
  logic          plot_in_range;

  assign plot_ready    = (state == IDLE) && !clear_req && !clear_pending;
  assign transfer      = plot_valid && plot_ready;
  assign plot_in_range = ({1'b0, plot_x} < (XW + 1)'(WIDTH)) &&
                         ({1'b0, plot_y} < (YW + 1)'(HEIGHT));

  // sweep_end marks that the last pixel is already on the port; the counter then idles at origin
  assign cnt_restart = ((state == CLEAR) && clear_req) ||
                       ((state == IDLE) && (clear_req || clear_pending));
  assign cnt_en      = (state == CLEAR) && (clear_req || !sweep_end);

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .en      (cnt_en),
    .restart (cnt_restart),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clear_busy    <= CLEAR_ON_RESET;
      clear_pending <= 1'b0;
      sweep_end     <= 1'b0;
      vga_x         <= '0;
      vga_y         <= '0;
      vga_colour    <= '0;
      vga_plot      <= 1'b0;
      clear_done    <= 1'b0;
      plot_oob      <= 1'b0;
    end else begin
      vga_plot   <= 1'b0;
      clear_done <= 1'b0;
      plot_oob   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear_req || clear_pending) begin
            state         <= CLEAR;
            clear_busy    <= 1'b1;
            clear_pending <= 1'b0;
            sweep_end     <= 1'b0;
          end else if (transfer) begin
            state <= PLOT;
            if (plot_in_range) begin
              vga_x      <= plot_x;
              vga_y      <= plot_y;
              vga_colour <= plot_colour;
              vga_plot   <= 1'b1;
            end else begin
              plot_oob <= 1'b1;
            end
          end
        end
        PLOT: begin
          state <= IDLE;
          if (clear_req) clear_pending <= 1'b1;
        end
        CLEAR: begin
          if (clear_req) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= BG_COLOUR;
            vga_plot   <= 1'b1;
            sweep_end  <= SINGLE_PIXEL;
          end else if (sweep_end) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            sweep_end  <= 1'b0;
          end else begin
            vga_x      <= cnt_x;
            vga_y      <= cnt_y;
            vga_colour <= BG_COLOUR;
            vga_plot   <= 1'b1;
            sweep_end  <= cnt_last;
          end
        end
        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
